// File: rtl/chip8_mem_pkg.sv
// Shared types for the CHIP-8 memory arbiter: address width, burst FSM states
// and the per-cycle grant source.
package chip8_mem_pkg;
  localparam int ADDR_W = 12;

  typedef enum logic {IDLE, BURST} state_e;

  typedef enum logic [1:0] {NONE, CPU_RD, CPU_WR, DMA} gnt_e;
endpackage

// File: rtl/mem_burst_ctr.sv
// Burst bookkeeping for the DMA reader: latches base/length on load and
// produces the wrapping read address for the current burst byte.
module mem_burst_ctr #(
  parameter int ADDR_W = 12
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [3:0]        i_len,
  input  logic              i_adv,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);
  logic [ADDR_W-1:0] r_base;
  logic [3:0]        r_idx;
  logic [3:0]        r_rem;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_base <= '0;
      r_idx  <= '0;
      r_rem  <= '0;
    end else if (i_load) begin
      r_base <= i_base;
      r_idx  <= '0;
      r_rem  <= i_len;
    end else if (i_adv) begin
      r_idx  <= r_idx + 4'd1;
      r_rem  <= r_rem - 4'd1;
    end
  end

  // Address arithmetic is ADDR_W wide, so the top of memory wraps to 0.
  assign o_addr = r_base + ADDR_W'(r_idx);
  assign o_last = (r_rem == 4'd1);
endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: CPU has priority, the DMA burst reader is
// guaranteed a slot after STARVE_MAX consecutive CPU grants.
module mem_arbiter
  import chip8_mem_pkg::*;
#(
  parameter int ADDR_W     = chip8_mem_pkg::ADDR_W,
  parameter int STARVE_MAX = 4
) (
  input  logic              fpga_clk,
  input  logic              rst_in,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [7:0]        cpu_rdata,
  input  logic              dma_start,
  input  logic [ADDR_W-1:0] dma_base,
  input  logic [3:0]        dma_len,
  output logic              dma_busy,
  output logic              dma_rvalid,
  output logic [7:0]        dma_rdata,
  output logic              dma_done,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [7:0]        mem_wdata,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [7:0]        mem_rdata
);
  localparam int SW = $clog2(STARVE_MAX + 1);

  state_e            r_state;
  state_e            w_state_nxt;
  gnt_e              w_grant;
  logic [SW-1:0]     r_starve;
  logic              r_cpu_vld_p1;
  logic              r_dma_vld_p1;
  logic              r_done_p1;
  logic              w_start;
  logic              w_load;
  logic              w_zero;
  logic              w_force;
  logic              w_last;
  logic [ADDR_W-1:0] w_dma_addr;

  // dma_start is only honoured while idle; a busy burst ignores it.
  assign w_start = dma_start && (r_state == IDLE) && !rst_in;
  assign w_load  = w_start && (dma_len != 4'd0);
  assign w_zero  = w_start && (dma_len == 4'd0);
  assign w_force = (r_state == BURST) && (r_starve >= SW'(STARVE_MAX));

  mem_burst_ctr #(.ADDR_W(ADDR_W)) u_burst_ctr (
    .i_clk  (fpga_clk),
    .i_rst  (rst_in),
    .i_load (w_load),
    .i_base (dma_base),
    .i_len  (dma_len),
    .i_adv  (w_grant == DMA),
    .o_addr (w_dma_addr),
    .o_last (w_last)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = NONE;
    if (!rst_in) begin
      if (cpu_req && !w_force) w_grant = cpu_we ? CPU_WR : CPU_RD;
      else if (r_state == BURST) w_grant = DMA;
    end
    case (r_state)
      IDLE:    if (w_load) w_state_nxt = BURST;
      BURST:   if ((w_grant == DMA) && w_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Stage p0 -> p1: grant decision becomes read-data valid one cycle later.
  always_ff @(posedge fpga_clk) begin
    if (rst_in) begin
      r_state      <= IDLE;
      r_starve     <= '0;
      r_cpu_vld_p1 <= 1'b0;
      r_dma_vld_p1 <= 1'b0;
      r_done_p1    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cpu_vld_p1 <= (w_grant == CPU_RD);
      r_dma_vld_p1 <= (w_grant == DMA);
      r_done_p1    <= ((w_grant == DMA) && w_last) || w_zero;
      if ((w_grant == DMA) || (r_state != BURST)) r_starve <= '0;
      else if ((w_grant == CPU_RD) || (w_grant == CPU_WR)) r_starve <= r_starve + 1'b1;
    end
  end

  assign cpu_gnt   = (w_grant == CPU_RD) || (w_grant == CPU_WR);
  assign mem_we    = (w_grant == CPU_WR);
  assign mem_waddr = mem_we ? cpu_addr  : '0;
  assign mem_wdata = mem_we ? cpu_wdata : '0;
  assign mem_raddr = (w_grant == CPU_RD) ? cpu_addr :
                     (w_grant == DMA)    ? w_dma_addr : '0;

  // Outputs are forced low for the whole reset window, dropping in-flight reads.
  assign cpu_rvalid = r_cpu_vld_p1 && !rst_in;
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign dma_rvalid = r_dma_vld_p1 && !rst_in;
  assign dma_rdata  = dma_rvalid ? mem_rdata : '0;
  assign dma_done   = r_done_p1 && !rst_in;
  assign dma_busy   = (r_state == BURST) && !rst_in;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 4 KiB synchronous memory.
module tb_mem_arbiter;
  logic        fpga_clk = 1'b0;
  logic        rst_in;
  logic        cpu_req, cpu_we;
  logic [11:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_gnt, cpu_rvalid;
  logic [7:0]  cpu_rdata;
  logic        dma_start;
  logic [11:0] dma_base;
  logic [3:0]  dma_len;
  logic        dma_busy, dma_rvalid, dma_done;
  logic [7:0]  dma_rdata;
  logic        mem_we;
  logic [11:0] mem_waddr, mem_raddr;
  logic [7:0]  mem_wdata, mem_rdata;

  logic [7:0]  mem [4096];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 fpga_clk = ~fpga_clk;

  mem_arbiter #(.ADDR_W(12), .STARVE_MAX(4)) dut (
    .fpga_clk(fpga_clk), .rst_in(rst_in),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_start(dma_start), .dma_base(dma_base), .dma_len(dma_len),
    .dma_busy(dma_busy), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata), .dma_done(dma_done),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
  );

  always @(posedge fpga_clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    mem_rdata <= mem[mem_raddr];
  end

  function automatic logic [7:0] pat(input logic [11:0] a);
    return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h5A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge fpga_clk);
    #2;
  endtask

  // Burst with the CPU idle: one address per cycle, data one cycle behind.
  task automatic run_burst(input logic [11:0] base, input logic [3:0] len);
    logic [11:0] a;
    dma_start = 1'b1; dma_base = base; dma_len = len;
    #1;
    chk("start_busy", 32'(dma_busy), 32'd0);
    step();
    dma_start = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      #1;
      if (i < int'(len)) begin
        a = base + 12'(i);
        chk("burst_raddr", 32'(mem_raddr), 32'(a));
        chk("burst_busy", 32'(dma_busy), 32'd1);
      end else begin
        chk("burst_busy_end", 32'(dma_busy), 32'd0);
      end
      chk("burst_rvalid", 32'(dma_rvalid), 32'(i > 0));
      if (i > 0) begin
        a = base + 12'(i - 1);
        chk("burst_rdata", 32'(dma_rdata), 32'(pat(a)));
      end
      chk("burst_done", 32'(dma_done), 32'(i == int'(len)));
      step();
    end
    #1;
    chk("burst_done_clr", 32'(dma_done), 32'd0);
    chk("burst_rvalid_clr", 32'(dma_rvalid), 32'd0);
  endtask

  initial begin
    logic        g_exp, g_prev;
    logic [11:0] a;
    for (int i = 0; i < 4096; i++) mem[i] = pat(12'(i));
    mem[12'h200] = 8'hA2;
    rst_in = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h123; cpu_wdata = 8'hFF;
    dma_start = 1'b0; dma_base = '0; dma_len = '0;
    step(); step();
    #1;
    chk("rst_gnt", 32'(cpu_gnt), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_waddr", 32'(mem_waddr), 32'd0);
    chk("rst_raddr", 32'(mem_raddr), 32'd0);
    chk("rst_busy", 32'(dma_busy), 32'd0);
    chk("rst_rvalid", 32'(cpu_rvalid), 32'd0);
    chk("rst_done", 32'(dma_done), 32'd0);

    // CPU read of 0x200
    rst_in = 1'b0; cpu_we = 1'b0; cpu_addr = 12'h200;
    #1;
    chk("rd_gnt", 32'(cpu_gnt), 32'd1);
    chk("rd_raddr", 32'(mem_raddr), 32'h200);
    step(); cpu_req = 1'b0; #1;
    chk("rd_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("rd_rdata", 32'(cpu_rdata), 32'hA2);
    chk("rd_gnt_idle", 32'(cpu_gnt), 32'd0);
    step(); #1;
    chk("rd_rvalid_clr", 32'(cpu_rvalid), 32'd0);

    // CPU write then read back
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h300; cpu_wdata = 8'h3C;
    #1;
    chk("wr_gnt", 32'(cpu_gnt), 32'd1);
    chk("wr_we", 32'(mem_we), 32'd1);
    chk("wr_waddr", 32'(mem_waddr), 32'h300);
    chk("wr_wdata", 32'(mem_wdata), 32'h3C);
    step(); cpu_req = 1'b0; cpu_we = 1'b0; #1;
    chk("wr_no_rvalid", 32'(cpu_rvalid), 32'd0);
    chk("wr_we_clr", 32'(mem_we), 32'd0);
    cpu_req = 1'b1;
    step(); cpu_req = 1'b0; #1;
    chk("wr_readback", 32'(cpu_rdata), 32'h3C);
    step();

    // Plain and wrapping bursts
    run_burst(12'h050, 4'd5);
    step();
    run_burst(12'hFFE, 4'd4);
    step();

    // Zero-length burst: immediate done, no memory read
    dma_start = 1'b1; dma_base = 12'h123; dma_len = 4'd0;
    #1;
    chk("len0_raddr0", 32'(mem_raddr), 32'd0);
    step(); dma_start = 1'b0; #1;
    chk("len0_done", 32'(dma_done), 32'd1);
    chk("len0_busy", 32'(dma_busy), 32'd0);
    chk("len0_raddr1", 32'(mem_raddr), 32'd0);
    chk("len0_rvalid", 32'(dma_rvalid), 32'd0);
    step(); #1;
    chk("len0_done_clr", 32'(dma_done), 32'd0);
    step();

    // Second start during a busy burst is ignored
    dma_start = 1'b1; dma_base = 12'h080; dma_len = 4'd2;
    step();
    dma_base = 12'h400; dma_len = 4'd7; #1;
    chk("ign_raddr0", 32'(mem_raddr), 32'h080);
    step(); dma_start = 1'b0; #1;
    chk("ign_raddr1", 32'(mem_raddr), 32'h081);
    chk("ign_rdata0", 32'(dma_rdata), 32'(pat(12'h080)));
    step(); #1;
    chk("ign_rdata1", 32'(dma_rdata), 32'(pat(12'h081)));
    chk("ign_done", 32'(dma_done), 32'd1);
    chk("ign_busy_end", 32'(dma_busy), 32'd0);
    step(); #1;
    chk("ign_no_restart", 32'(dma_busy), 32'd0);
    chk("ign_done_clr", 32'(dma_done), 32'd0);
    step();

    // Continuous CPU reads with a 3-byte burst: 4 CPU, 1 DMA, repeating
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h200;
    dma_start = 1'b1; dma_base = 12'h060; dma_len = 4'd3;
    #1;
    chk("st_gnt0", 32'(cpu_gnt), 32'd1);
    g_prev = 1'b1;
    step(); dma_start = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      #1;
      g_exp = (k > 15) || ((k % 5) != 0);
      chk("st_gnt", 32'(cpu_gnt), 32'(g_exp));
      chk("st_cpu_rvalid", 32'(cpu_rvalid), 32'(g_prev));
      if (!g_exp) begin
        a = 12'h060 + 12'(k / 5 - 1);
        chk("st_dma_raddr", 32'(mem_raddr), 32'(a));
      end
      chk("st_dma_rvalid", 32'(dma_rvalid), 32'((k % 5) == 1 && k > 1));
      if ((k % 5) == 1 && k > 1) begin
        a = 12'h060 + 12'(k / 5 - 1);
        chk("st_dma_rdata", 32'(dma_rdata), 32'(pat(a)));
      end
      chk("st_done", 32'(dma_done), 32'(k == 16));
      g_prev = g_exp;
      step();
    end
    cpu_req = 1'b0;
    step(); step();

    // Reset in the middle of a 6-byte burst
    dma_start = 1'b1; dma_base = 12'h090; dma_len = 4'd6;
    step(); dma_start = 1'b0;
    step(); #1;
    chk("rb_byte0", 32'(dma_rdata), 32'(pat(12'h090)));
    step(); #1;
    chk("rb_byte1", 32'(dma_rdata), 32'(pat(12'h091)));
    step();
    rst_in = 1'b1; #1;
    chk("rb_in_rst_rvalid", 32'(dma_rvalid), 32'd0);
    chk("rb_in_rst_raddr", 32'(mem_raddr), 32'd0);
    chk("rb_in_rst_busy", 32'(dma_busy), 32'd0);
    step(); rst_in = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("rb_busy", 32'(dma_busy), 32'd0);
      chk("rb_rvalid", 32'(dma_rvalid), 32'd0);
      chk("rb_done", 32'(dma_done), 32'd0);
      chk("rb_raddr", 32'(mem_raddr), 32'd0);
      step();
    end
    run_burst(12'h0A0, 4'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12, memory address width (4096 bytes).
REQ-002 Parameter STARVE_MAX, default 4, max consecutive CPU grants while the DMA reader waits.
REQ-003 fpga_clk  in  1  sole clock; all logic on rising edge.
REQ-004 rst_in  in  1  synchronous, active-high reset.
REQ-005 cpu_req  in  1  CPU access request, held until granted.
REQ-006 cpu_we  in  1  1 = write, 0 = read; valid with cpu_req.
REQ-007 cpu_addr  in  ADDR_W  CPU byte address.
REQ-008 cpu_wdata  in  8  CPU write data.
REQ-009 cpu_gnt  out  1  request accepted this cycle.
REQ-010 cpu_rvalid  out  1  CPU read data valid.
REQ-011 cpu_rdata  out  8  CPU read data.
REQ-012 dma_start  in  1  one-cycle pulse; starts a burst read (sprite/display fetch).
REQ-013 dma_base  in  ADDR_W  burst start address; sampled on dma_start.
REQ-014 dma_len  in  4  burst length in bytes, 0..15; sampled on dma_start.
REQ-015 dma_busy  out  1  burst in progress.
REQ-016 dma_rvalid / dma_rdata  out  1 / 8  one burst byte, in address order.
REQ-017 dma_done  out  1  one-cycle pulse after the last burst byte.
REQ-018 mem_we, mem_waddr, mem_wdata  out  1, ADDR_W, 8  memory write port.
REQ-019 mem_raddr  out  ADDR_W  memory read address; mem_rdata  in  8  registered read data, 1-cycle latency.

Function
REQ-020 At most one memory access (read or write) is issued per cycle.
REQ-021 States: IDLE (no burst) and BURST (bytes remaining); dma_start in IDLE with dma_len>0 enters BURST; issuing the last byte returns to IDLE.
REQ-022 dma_start in IDLE with dma_len=0 leaves the FSM in IDLE and pulses dma_done the next cycle with no memory access.
REQ-023 dma_start while dma_busy=1 is ignored.
REQ-024 Priority: CPU wins, except after STARVE_MAX consecutive CPU grants while BURST is pending, the next slot goes to DMA; the counter clears on any DMA grant or when not in BURST.
REQ-025 cpu_gnt is combinational from cpu_req and the arbitration decision in the same cycle.
REQ-026 A granted CPU write drives mem_we=1, mem_waddr=cpu_addr, mem_wdata=cpu_wdata that cycle; no rvalid follows.
REQ-027 A granted CPU read drives mem_raddr=cpu_addr; cpu_rvalid=1 with cpu_rdata=mem_rdata exactly one cycle later.
REQ-028 A DMA slot drives mem_raddr=(dma_base+index) mod 2^ADDR_W; dma_rvalid follows one cycle later; the address wraps 4095 -> 0.
REQ-029 dma_done pulses in the same cycle as the final dma_rvalid; dma_busy falls in that cycle.
REQ-030 mem_we is 0 in every cycle without a granted CPU write.

Reset
REQ-031 While rst_in=1: FSM=IDLE, index/remaining/starvation counters=0, and cpu_gnt, cpu_rvalid, dma_busy, dma_rvalid, dma_done, mem_we=0; rdata outputs, mem_raddr, mem_waddr, mem_wdata=0.
REQ-032 Reset during BURST aborts it: no further dma_rvalid and no dma_done; in-flight rvalids are dropped.

Structure
REQ-033 Package chip8_mem_pkg holds ADDR_W, the FSM state enum, and the grant-source enum (NONE, CPU_RD, CPU_WR, DMA).
REQ-034 Sub-module mem_burst_ctr holds the burst index/remaining counters and address generation; the arbitration decision stays in mem_arbiter.

Verification
REQ-035 CPU read 0x200 (mem holds 0xA2) with no DMA -> cpu_gnt same cycle, cpu_rvalid next cycle with 0xA2.
REQ-036 dma_start base=0x050 len=5, CPU idle -> dma_rvalid 5 consecutive cycles, addresses 0x050..0x054, dma_done with the 5th byte.
REQ-037 Continuous CPU reads plus burst len=3 -> pattern 4 CPU grants, 1 DMA grant, repeating; all 3 bytes are delivered, and dma_done fires.
REQ-038 base=0xFFE len=4 -> addresses 0xFFE, 0xFFF, 0x000, 0x001.
REQ-039 len=0 -> dma_done next cycle, mem_raddr is never driven for DMA; second dma_start during busy -> ignored, original burst completes.
REQ-040 rst_in asserted after 2 of 6 burst bytes -> no dma_done, all outputs 0 the next cycle, a new burst works afterwards.
